// File: rtl/otter_io_pkg.sv
// Shared state type and register map for the OTTER UART transmitter.
package otter_io_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic [3:0] UART_DATA_OFS = 4'h0;
  localparam logic [3:0] UART_STAT_OFS = 4'h4;
  localparam logic [3:0] UART_CTRL_OFS = 4'h8;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_COUNT = 8;

endpackage

// File: rtl/otter_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module otter_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/otter_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the OTTER IO bus: register decode,
// FIFO buffering, bit-timing FSM and a level interrupt.
module otter_uart_tx
  import otter_io_pkg::*;
#(
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h1100_00C0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        RD_HIT,
  output logic        TX,
  output logic        IRQ
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("otter_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("otter_uart_tx: FIFO_DEPTH must be a power of 2 in 2..256");
  end

  logic [31:0]   ofs;
  logic          hit;
  logic          data_wr;
  logic          stat_wr;
  logic          ctrl_wr;
  logic          ovf_set;
  logic          overflow;
  logic          irq_en;
  logic [31:0]   status;
  logic          unused_iobus;

  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  uart_state_t   state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;

  // BASE_ADDR is word aligned, so the low offset bits are the address bits.
  assign ofs     = IOBUS_ADDR - BASE_ADDR;
  assign hit     = (ofs[1:0] == 2'b00) && (ofs < 32'd12);
  assign data_wr = IOBUS_WR && hit && (ofs[3:0] == UART_DATA_OFS);
  assign stat_wr = IOBUS_WR && hit && (ofs[3:0] == UART_STAT_OFS);
  assign ctrl_wr = IOBUS_WR && hit && (ofs[3:0] == UART_CTRL_OFS);
  assign ovf_set = data_wr && fifo_full && !fifo_pop;
  assign RD_HIT  = hit;
  assign unused_iobus = &{1'b0, IOBUS_OUT[31:8]};

  otter_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (data_wr),
    .pop   (fifo_pop),
    .din   (IOBUS_OUT[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                     = '0;
    status[STAT_BUSY]          = (state != IDLE);
    status[STAT_FULL]          = fifo_full;
    status[STAT_EMPTY]         = fifo_empty;
    status[STAT_OVF]           = overflow;
    status[STAT_COUNT +: CW]   = fifo_count;
    RD_DATA                    = '0;
    if (hit) begin
      case (ofs[3:0])
        UART_STAT_OFS: RD_DATA = status;
        UART_CTRL_OFS: RD_DATA = {31'b0, irq_en};
        default:       RD_DATA = '0;
      endcase
    end
  end

  // An overflow on the same edge as a clear request keeps the flag set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      if (ovf_set)                    overflow <= 1'b1;
      else if (stat_wr && IOBUS_OUT[3]) overflow <= 1'b0;
      if (ctrl_wr) irq_en <= IOBUS_OUT[0];
      IRQ <= irq_en && fifo_empty && (state == IDLE);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      TX       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      TX       <= tx_n;
    end
  end

  // Each state holds its line level for DIV cycles, advancing when the
  // counter reads zero.
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_idx;
    shift_n  = shift;
    tx_n     = TX;
    fifo_pop = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_dout;
          tx_n     = 1'b0;
          baud_n   = BAUD_RELOAD;
          state_n  = START;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          tx_n    = shift[0];
          bit_n   = '0;
          baud_n  = BAUD_RELOAD;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_n = BAUD_RELOAD;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
            bit_n   = bit_idx + 1'b1;
          end
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == '0) state_n = IDLE;
        else                baud_n  = baud_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_otter_uart_tx.sv
// Directed bench for otter_uart_tx with DIV=4 and a 4-entry FIFO: a register
// access table followed by hand-written frame, overflow, IRQ and reset sequences.
module tb_otter_uart_tx;

  localparam logic [31:0] BASE   = 32'h1100_00C0;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_CTRL = BASE + 32'd8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] RD_DATA;
  logic        RD_HIT;
  logic        TX;
  logic        IRQ;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [16];

  otter_uart_tx #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (250_000),
    .FIFO_DEPTH (4),
    .BASE_ADDR  (BASE)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .RD_DATA    (RD_DATA),
    .RD_HIT     (RD_HIT),
    .TX         (TX),
    .IRQ        (IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    IOBUS_WR = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic wr);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = wr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkStatus(input string name, input logic [31:0] expected);
    applyStimulus(A_STAT, 32'h0, 1'b0);
    #1;
    checkOutput(name, RD_DATA, expected);
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(addr, data, 1'b1);
    tick();
  endtask

  // Checks line cycles first..39 of a frame; cycle i is sampled after the
  // i-th edge counted from the edge that drove the start bit.
  task automatic checkFrame(input logic [7:0] b, input string name, input int first);
    logic exp_bit;
    for (int i = first; i < 40; i++) begin
      tick();
      if (i < 4)       exp_bit = 1'b0;
      else if (i < 36) exp_bit = b[(i - 4) / 4];
      else             exp_bit = 1'b1;
      checkOutput($sformatf("%s cycle %0d", name, i), {31'b0, TX}, {31'b0, exp_bit});
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, A_STAT,          32'h0,         32'h4, 1'b1};
    vecs[1]  = '{1'b0, A_DATA,          32'h0,         32'h0, 1'b1};
    vecs[2]  = '{1'b0, A_CTRL,          32'h0,         32'h0, 1'b1};
    vecs[3]  = '{1'b0, BASE + 32'd12,   32'h0,         32'h0, 1'b0};
    vecs[4]  = '{1'b0, BASE + 32'd6,    32'h0,         32'h0, 1'b0};
    vecs[5]  = '{1'b0, BASE - 32'd4,    32'h0,         32'h0, 1'b0};
    vecs[6]  = '{1'b1, A_CTRL,          32'h1,         32'h0, 1'b0};
    vecs[7]  = '{1'b0, A_CTRL,          32'h0,         32'h1, 1'b1};
    vecs[8]  = '{1'b1, A_CTRL,          32'hFFFF_FFFE, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, A_CTRL,          32'h0,         32'h0, 1'b1};
    vecs[10] = '{1'b1, BASE + 32'd12,   32'hFF,        32'h0, 1'b0};
    vecs[11] = '{1'b1, BASE + 32'd1,    32'hFF,        32'h0, 1'b0};
    vecs[12] = '{1'b0, A_STAT,          32'h0,         32'h4, 1'b1};
    vecs[13] = '{1'b1, A_STAT,          32'h8,         32'h0, 1'b0};
    vecs[14] = '{1'b0, A_STAT,          32'h0,         32'h4, 1'b1};
    vecs[15] = '{1'b0, 32'h0000_00C4,   32'h0,         32'h0, 1'b0};

    // Reset state, sampled while reset is held.
    #12;
    checkOutput("reset TX", {31'b0, TX}, 32'h1);
    checkOutput("reset IRQ", {31'b0, IRQ}, 32'h0);
    checkStatus("reset STATUS", 32'h4);
    RST_N = 1'b1;
    tick();

    $display("[TB] register access table");
    for (int v = 0; v < 16; v++) begin
      if (vecs[v].wr) begin
        writeReg(vecs[v].addr, vecs[v].wdata);
      end else begin
        applyStimulus(vecs[v].addr, 32'h0, 1'b0);
        #1;
        checkOutput($sformatf("vec%0d hit", v), {31'b0, RD_HIT}, {31'b0, vecs[v].exp_hit});
        if (vecs[v].exp_hit)
          checkOutput($sformatf("vec%0d data", v), RD_DATA, vecs[v].exp_data);
        tick();
      end
    end

    $display("[TB] single frame 0x55");
    writeReg(A_DATA, 32'h55);
    checkOutput("latency TX still high", {31'b0, TX}, 32'h1);
    checkFrame(8'h55, "frame55", 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post55 idle TX", {31'b0, TX}, 32'h1);
    end
    checkStatus("post55 STATUS", 32'h4);

    $display("[TB] back-to-back 0xA3, 0x0F");
    applyStimulus(A_DATA, 32'hA3, 1'b1);
    tick();
    applyStimulus(A_DATA, 32'h0F, 1'b1);
    checkFrame(8'hA3, "frameA3", 0);
    checkStatus("frameA3 STATUS", 32'h101);
    tick();
    checkOutput("gap TX", {31'b0, TX}, 32'h1);
    checkFrame(8'h0F, "frame0F", 0);
    checkStatus("frame0F stop STATUS", 32'h5);
    tick();
    checkStatus("after0F STATUS", 32'h4);
    checkOutput("after0F TX", {31'b0, TX}, 32'h1);

    $display("[TB] overflow with six writes");
    for (int k = 0; k < 6; k++) writeReg(A_DATA, (k + 1) * 32'h11);
    checkStatus("overflow STATUS", 32'h40B);
    writeReg(A_STAT, 32'h8);
    checkStatus("ovf cleared STATUS", 32'h403);
    checkFrame(8'h11, "ovf frame1", 6);
    for (int k = 1; k < 5; k++) begin
      tick();
      checkOutput($sformatf("ovf gap%0d TX", k), {31'b0, TX}, 32'h1);
      checkFrame(8'((k + 1) * 8'h11), $sformatf("ovf frame%0d", k + 1), 0);
    end
    for (int i = 0; i < 45; i++) begin
      tick();
      checkOutput("ovf tail TX", {31'b0, TX}, 32'h1);
    end
    checkStatus("ovf tail STATUS", 32'h4);

    $display("[TB] interrupt");
    writeReg(A_DATA, 32'h5A);
    writeReg(A_CTRL, 32'h1);
    checkOutput("irq frame start", {31'b0, IRQ}, 32'h0);
    for (int i = 1; i < 40; i++) begin
      tick();
      if (i % 10 == 0) checkOutput($sformatf("irq during frame %0d", i), {31'b0, IRQ}, 32'h0);
    end
    tick();
    checkOutput("irq at idle entry", {31'b0, IRQ}, 32'h0);
    tick();
    checkOutput("irq raised", {31'b0, IRQ}, 32'h1);
    writeReg(A_CTRL, 32'h0);
    checkOutput("irq after disable edge", {31'b0, IRQ}, 32'h1);
    tick();
    checkOutput("irq dropped", {31'b0, IRQ}, 32'h0);

    $display("[TB] reset mid-frame");
    writeReg(A_DATA, 32'h00);
    writeReg(A_DATA, 32'h00);
    for (int i = 1; i < 15; i++) tick();
    checkOutput("pre-reset TX", {31'b0, TX}, 32'h0);
    checkStatus("pre-reset STATUS", 32'h101);
    RST_N = 1'b0;
    #1;
    checkOutput("async reset TX", {31'b0, TX}, 32'h1);
    checkOutput("async reset IRQ", {31'b0, IRQ}, 32'h0);
    checkStatus("async reset STATUS", 32'h4);
    #2;
    RST_N = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checkOutput("post-reset TX", {31'b0, TX}, 32'h1);
    end
    checkStatus("post-reset STATUS", 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otter_uart_tx.md
Name: otter_uart_tx

Overview:
- Memory-mapped UART transmitter on the MCU IO bus, directly downstream of the OTTER core.
- Consumes the core's IOBUS_ADDR, IOBUS_OUT and IOBUS_WR.
- Buffers written bytes in a FIFO and serialises them 8N1, LSB first, on TX.
- Returns status and control words on a read port that the top-level IO mux routes to IOBUS_IN.
- Raises a level interrupt for the core's INTR input.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD, 115_200, line rate. DIV = CLK_FREQ/BAUD (integer, truncating) clocks per bit. DIV ≥ 2 is required; DIV < 2 is an elaboration error.
- FIFO_DEPTH, 16, entries. Power of 2, 2..256.
- BASE_ADDR, 32'h1100_00C0, word-aligned base of the 3-register window.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IOBUS_ADDR  in  32  byte address from core.
- IOBUS_OUT  in  32  write data from core.
- IOBUS_WR  in  1  write strobe, one cycle per store.
- RD_DATA  out  32  read data for the addressed register; combinational.
- RD_HIT  out  1  IOBUS_ADDR falls in the 3-register window; combinational.
- TX  out  1  serial line, registered, idle high.
- IRQ  out  1  level interrupt, registered.

Behaviour:
- Register map (offsets from BASE_ADDR; a hit requires IOBUS_ADDR[1:0]==0):
  - 0x0 DATA: write pushes IOBUS_OUT[7:0]. Reads return 0.
  - 0x4 STATUS, read: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[16:8] fifo count. Write 1 to bit3 clears overflow.
  - 0x8 CTRL, read/write: bit0 irq_en.
  - Unlisted bits read 0. Writes to unlisted offsets are ignored.
- Reset (RST_N low, asynchronous): TX=1, IRQ=0, FIFO empty, overflow=0, irq_en=0, FSM=IDLE, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame: TX returns high immediately and the FIFO contents are discarded.
- FIFO push: DATA write with count<FIFO_DEPTH, or count==FIFO_DEPTH and a pop in the same cycle. In the second case count is unchanged.
- FIFO overflow: DATA write when full with no simultaneous pop. The byte is dropped and overflow is set on that edge.
- FSM states:
  - IDLE: if FIFO not empty, pop, load the shift register, TX<=0, go to START. Baud counter reloads to DIV-1.
  - START: hold TX=0 for DIV cycles, then TX<=shift[0], go to DATA with bit index 0.
  - DATA: each bit is held DIV cycles, then shift right. After bit 7 completes, TX<=1 and go to STOP.
  - STOP: hold TX=1 for DIV cycles, then go to IDLE.
- Latency: a DATA write captured on edge E with the FIFO previously empty and FSM IDLE drives TX low after edge E+1.
- The frame is 10*DIV cycles long. STOP→IDLE→START adds 1 idle-high cycle between back-to-back frames, so the frame period is 10*DIV+1.
- Baud counter: counts down from DIV-1 to 0. The state/bit advances on the cycle it reads 0, then the counter reloads.
- IRQ is registered from: irq_en AND empty AND FSM==IDLE.
- Simultaneous STATUS overflow-clear write and overflow event in the same cycle: the set wins.
- Count width: $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package otter_io_pkg:
  - uart_state_t enum {IDLE, START, DATA, STOP}.
  - Register offset constants UART_DATA_OFS=0x0, UART_STAT_OFS=0x4, UART_CTRL_OFS=0x8.
  - STATUS bit-index constants.
- Sub-module otter_sync_fifo (parameters WIDTH, DEPTH):
  - Ports: push, pop, din, dout, full, empty, count.
  - Same clock and RST_N.
  - First-word-fall-through dout.
- otter_uart_tx holds the register decode, the FSM and the baud counter.

Test Plan (CLK_FREQ=1_000_000, BAUD=250_000 → DIV=4, FIFO_DEPTH=4):
- Write 0x55 to DATA → TX low 1 cycle after the write edge; line reads 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 total), then stays 1.
- Write 0xA3 then 0x0F on consecutive cycles → two frames, 41-cycle period; STATUS reads busy=1, count=1 during frame 1; count=0 and busy=0 after the second stop bit.
- Write 6 bytes back-to-back with the FSM initially IDLE → the first byte pops on the second write's cycle, so 5 bytes are retained (1 in the shift register, 4 in the FIFO); the 6th write sets overflow=1 and STATUS shows full=1. Writing 0x8 to STATUS clears overflow; 5 frames are transmitted.
- CTRL=1, one byte written → IRQ=0 while transmitting; IRQ=1 one cycle after return to IDLE with an empty FIFO; writing CTRL=0 drops IRQ the following cycle.
- Assert RST_N low 15 cycles into a frame → TX=1, IRQ=0 and STATUS empty=1 immediately (asynchronous); after release no residual frame is sent.
- Read 0x1100_00C4 with the FIFO empty → RD_HIT=1, RD_DATA=32'h0000_0004; read 0x1100_00CC → RD_HIT=0.
